conv_load_sequencer: RTL
========================

# conv_load_sequencer

Hardware replacement for the bench-side stimulus of the 3D convolution `top`. On `start` it reads the 9x9 RGB image and both 3x3x3 filters from external synchronous-read memories and drives `top`'s load protocol (`rst_data`, `ld`, `lf_0`/`lf_1`, `go`). It then collects every `Out` word qualified by `out_valid` into a small FIFO and presents the words on a valid/ready result stream. It sits between the on-chip image/filter storage and `top`.

## Interface
- `stride`, default 1: must match `top`'s stride.
- `IMG_W`, default 9: image side; image length is `IMG_W*IMG_W` = 81.
- `K`, default 3: filter side; filter length is `K*K` = 9.
- `N_OUT`, default `2*((IMG_W-K)/stride+1)**2` = 98: expected `out_valid` count (two filters).
- `FIFO_DEPTH`, default 4: result FIFO depth, a power of 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; asserted low, all state clears immediately.
- `start`  in  1  one-cycle request; ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` until the DONE state exits.
- `seq_done`  out  1  one-cycle pulse at completion.
- `err_ovf`  out  1  sticky: FIFO overflow; cleared on an accepted `start`.
- `err_short`  out  1  sticky: `conv_done` arrived before `N_OUT` outputs; cleared on an accepted `start`.
- `img_addr`  out  7  image memory address.
- `img_r`, `img_g`, `img_b`  in  8 each  signed image data, valid one cycle after address.
- `flt_addr`  out  4  filter memory address.
- `f0_r`, `f0_g`, `f0_b`, `f1_r`, `f1_g`, `f1_b`  in  8 each  signed filter data, same 1-cycle latency.
- `rst_data`, `ld`, `lf_0`, `lf_1`, `go`  out  1 each  to `top`.
- `data_in_R/G/B`, `data_in_f0_R/G/B`, `data_in_f1_R/G/B`  out  8 each  to `top`; wired combinationally from the memory data inputs.
- `conv_out`  in  32  signed `Out` of `top`.
- `out_valid`, `conv_done`  in  1 each  from `top`.
- `res_data`  out  32  FIFO head.
- `res_valid`  out  1  FIFO not empty.
- `res_ready`  in  1  consumer accept.

## Operation
- States: IDLE, CLR, IMG, FCLR, FLT, GO, RUN, DONE. All control outputs are registered and decoded from the state.
- **IDLE**: all controls low, addresses 0. `start` moves to CLR and clears the error flags, the output counter and the FIFO.
- **CLR** (1 cycle): `rst_data`=1, `img_addr`=0.
- **IMG** (81 cycles): `ld`=1. In cycle k, `img_addr`=k+1, and memory data for address k is on `data_in_*`. After k=80, go to FCLR.
- **FCLR** (1 cycle): `rst_data`=1, `lf_0`=`lf_1`=1, `flt_addr`=0.
- **FLT** (9 cycles): `lf_0`=`lf_1`=1, `flt_addr`=k+1. After k=8, go to GO.
- **GO** (1 cycle): `go`=1.
- **RUN**:
  - Each cycle with `out_valid`=1 pushes `conv_out` into the FIFO and increments the output counter (7 bits, saturating).
  - Counter reaching `N_OUT` moves to DONE.
  - `conv_done`=1 with counter < `N_OUT` sets `err_short` and moves to DONE.
- **DONE** (1 cycle): `seq_done`=1, then IDLE. `busy` drops in the cycle after DONE.
- FIFO:
  - Push on `out_valid` (only in RUN); pop on `res_valid && res_ready`.
  - Push while full with no pop in the same cycle: the word is dropped, `err_ovf`=1, and the counter still increments.
  - Push and pop in the same cycle while full: legal, no overflow.
  - The FIFO keeps draining after DONE/IDLE. An accepted `start` flushes it.
- `out_valid` outside RUN is ignored.
- `reset` low mid-sequence: every output returns to 0 asynchronously, state goes to IDLE, FIFO empties, error flags clear.

## Timing
- Reset value of every output: 0.
- `start` sampled at edge t: CLR is at t+1, first `ld` at t+2, last `ld` at t+82, FCLR at t+83, FLT at t+84..t+92, `go` at t+93.
- Fixed load overhead: 93 cycles from `start` to `go`.
- Result latency: a word pushed at edge t shows on `res_data`/`res_valid` from t+1.
- Throughput: one push and one pop per cycle.
- `seq_done` is asserted in the cycle after the final push (or after the `conv_done` edge).

## Test plan
- Reset then `start`:
  - Requires `ld` high exactly 81 cycles and `lf_0`/`lf_1` high 10 cycles (FCLR plus 9).
  - Requires a one-cycle `go` at start+93, and `img_addr` running 0..81.
- Image memory data = address, filters all 1, with real `top`, `res_ready`=1:
  - Requires 98 words equal to the software-model outputs.
  - Requires a `seq_done` pulse, `err_ovf`=0, `err_short`=0.
- `res_ready`=0 throughout RUN: requires 4 words retained, `err_ovf`=1, counter still reaching 98, `seq_done` pulse.
- Model `top` asserting `conv_done` after 50 outputs: requires `err_short`=1, `seq_done` pulse, return to IDLE.
- `reset` low at start+40 (mid-IMG): requires all outputs 0 immediately and no `go`. A new `start` must then produce a complete, correct run.
- `start` pulsed during RUN: requires it ignored, errors not cleared, counts unchanged.

Source files
------------

// File: rtl/conv_load_sequencer_if.sv
// Result stream between conv_load_sequencer and its consumer.
//   res_data  : signed 32-bit word at the FIFO head
//   res_valid : a word is available
//   res_ready : consumer accepts the word this cycle
interface conv_load_sequencer_if;
    logic signed [31:0] res_data;
    logic               res_valid;
    logic               res_ready;

    modport master (output res_data, output res_valid, input res_ready);
    modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/conv_load_sequencer.sv
// conv_load_sequencer: on start, streams the image and both filters from
// synchronous-read memories into the convolution core (rst_data/ld/lf_0/lf_1/go),
// then captures every out_valid word into a small FIFO presented on a
// valid/ready stream.
// Ports:
//   clk, reset (async, active-low)
//   start / busy / seq_done / err_ovf / err_short : sequence control and status
//   img_addr, img_r/g/b        : image memory (1-cycle read latency)
//   flt_addr, f0_*/f1_*        : filter memories (1-cycle read latency)
//   rst_data, ld, lf_0, lf_1, go, data_in_* : load protocol to the core
//   conv_out, out_valid, conv_done          : results from the core
//   res (master)               : result stream
module conv_load_sequencer #(
    parameter int stride     = 1,
    parameter int IMG_W      = 9,
    parameter int K          = 3,
    parameter int N_OUT      = 2 * ((IMG_W - K) / stride + 1) ** 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8,
    parameter int COEF_W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     seq_done,
    output logic                     err_ovf,
    output logic                     err_short,
    output logic [6:0]               img_addr,
    input  logic signed [DATA_W-1:0] img_r,
    input  logic signed [DATA_W-1:0] img_g,
    input  logic signed [DATA_W-1:0] img_b,
    output logic [3:0]               flt_addr,
    input  logic signed [COEF_W-1:0] f0_r,
    input  logic signed [COEF_W-1:0] f0_g,
    input  logic signed [COEF_W-1:0] f0_b,
    input  logic signed [COEF_W-1:0] f1_r,
    input  logic signed [COEF_W-1:0] f1_g,
    input  logic signed [COEF_W-1:0] f1_b,
    output logic                     rst_data,
    output logic                     ld,
    output logic                     lf_0,
    output logic                     lf_1,
    output logic                     go,
    output logic signed [DATA_W-1:0] data_in_R,
    output logic signed [DATA_W-1:0] data_in_G,
    output logic signed [DATA_W-1:0] data_in_B,
    output logic signed [COEF_W-1:0] data_in_f0_R,
    output logic signed [COEF_W-1:0] data_in_f0_G,
    output logic signed [COEF_W-1:0] data_in_f0_B,
    output logic signed [COEF_W-1:0] data_in_f1_R,
    output logic signed [COEF_W-1:0] data_in_f1_G,
    output logic signed [COEF_W-1:0] data_in_f1_B,
    input  logic signed [31:0]       conv_out,
    input  logic                     out_valid,
    input  logic                     conv_done,
    conv_load_sequencer_if.master    res
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [6:0] IMG_LEN = 7'(IMG_W * IMG_W);
    localparam logic [3:0] FLT_LEN = 4'(K * K);
    localparam logic [6:0] N_OUT_C = 7'(N_OUT);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_IMG, S_FCLR, S_FLT, S_GO, S_RUN, S_DONE} state_t;

    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v == 7'h7f) ? v : v + 7'd1;
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  img_addr_q, img_addr_d;
    logic [3:0]  flt_addr_q, flt_addr_d;
    logic [6:0]  cnt_q, cnt_d, cnt_inc;
    logic        err_ovf_q, err_ovf_d, err_short_q, err_short_d;
    logic        busy_q, busy_d, seq_done_q, seq_done_d;
    logic        rst_data_q, rst_data_d, ld_q, ld_d, lf_q, lf_d, go_q, go_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic signed [31:0] mem_q [FIFO_DEPTH];
    logic        full, empty, push, pop, wr_en, start_acc;

    // Memory data passes straight through; addresses were issued a cycle earlier.
    assign data_in_R    = img_r;
    assign data_in_G    = img_g;
    assign data_in_B    = img_b;
    assign data_in_f0_R = f0_r;
    assign data_in_f0_G = f0_g;
    assign data_in_f0_B = f0_b;
    assign data_in_f1_R = f1_r;
    assign data_in_f1_G = f1_g;
    assign data_in_f1_B = f1_b;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign start_acc = (state_q == S_IDLE) && start;
    assign push      = (state_q == S_RUN) && out_valid;
    assign pop       = !empty && res.res_ready;
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    assign wr_en     = push && (!full || pop);
    assign cnt_inc   = push ? sat_inc(cnt_q) : cnt_q;

    always_comb begin
        state_d     = state_q;
        img_addr_d  = '0;
        flt_addr_d  = '0;
        cnt_d       = cnt_q;
        err_ovf_d   = err_ovf_q;
        err_short_d = err_short_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d     = S_CLR;
                cnt_d       = '0;
                err_ovf_d   = 1'b0;
                err_short_d = 1'b0;
            end
            S_CLR: begin
                state_d    = S_IMG;
                img_addr_d = 7'd1;
            end
            // img_addr leads the data by one, so it runs 1..IMG_LEN here.
            S_IMG: if (img_addr_q == IMG_LEN) state_d = S_FCLR;
                   else img_addr_d = img_addr_q + 7'd1;
            S_FCLR: begin
                state_d    = S_FLT;
                flt_addr_d = 4'd1;
            end
            S_FLT: if (flt_addr_q == FLT_LEN) state_d = S_GO;
                   else flt_addr_d = flt_addr_q + 4'd1;
            S_GO: state_d = S_RUN;
            S_RUN: begin
                cnt_d = cnt_inc;
                if (push && full && !pop) err_ovf_d = 1'b1;
                if (cnt_inc >= N_OUT_C) state_d = S_DONE;
                else if (conv_done) begin
                    err_short_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Control outputs are registered versions of the next-state decode,
        // so they line up with the state they belong to.
        busy_d     = (state_d != S_IDLE);
        seq_done_d = (state_d == S_DONE);
        rst_data_d = (state_d == S_CLR) || (state_d == S_FCLR);
        ld_d       = (state_d == S_IMG);
        lf_d       = (state_d == S_FCLR) || (state_d == S_FLT);
        go_d       = (state_d == S_GO);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (start_acc) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            img_addr_q  <= '0;
            flt_addr_q  <= '0;
            cnt_q       <= '0;
            err_ovf_q   <= 1'b0;
            err_short_q <= 1'b0;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            rst_data_q  <= 1'b0;
            ld_q        <= 1'b0;
            lf_q        <= 1'b0;
            go_q        <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            img_addr_q  <= img_addr_d;
            flt_addr_q  <= flt_addr_d;
            cnt_q       <= cnt_d;
            err_ovf_q   <= err_ovf_d;
            err_short_q <= err_short_d;
            busy_q      <= busy_d;
            seq_done_q  <= seq_done_d;
            rst_data_q  <= rst_data_d;
            ld_q        <= ld_d;
            lf_q        <= lf_d;
            go_q        <= go_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= conv_out;
    end

    assign busy          = busy_q;
    assign seq_done      = seq_done_q;
    assign err_ovf       = err_ovf_q;
    assign err_short     = err_short_q;
    assign img_addr      = img_addr_q;
    assign flt_addr      = flt_addr_q;
    assign rst_data      = rst_data_q;
    assign ld            = ld_q;
    assign lf_0          = lf_q;
    assign lf_1          = lf_q;
    assign go            = go_q;
    assign res.res_valid = !empty;
    // Forced to zero when empty so the stream never shows stale storage.
    assign res.res_data  = empty ? 32'sd0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule
